audio_fifo_i2s: RTL and testbench
=================================

// Module: audio_fifo_i2s
// PURPOSE
// - Sample buffer and I2S transmitter directly downstream of the synth voice engine.
// - Accepts 32-bit TONE words on LD_FIFO into a FIFO and back-pressures the engine via FIFO_FULL.
// - Pops one sample per audio frame and serialises it MSB-first, same word on L and R, to the codec DAC.
// PARAMETERS
// - DEPTH      16  FIFO entries, power of 2, >=4
// - DATA_W     24  bits sent per channel, taken from TONE[31:32-DATA_W]
// - BCLK_DIV   8   CLK cycles per BCLK half-period (50 MHz -> 3.125 MHz BCLK, 48.83 kHz frame)
// - FRAME_BITS 32  BCLK periods per channel slot, >= DATA_W+1
// PORTS
// - CLK        in   1              system clock
// - RESET      in   1              async, active-high
// - ENABLE     in   1              1 = run serialiser; 0 = serialiser idle, FIFO still accepts writes
// - LD_FIFO    in   1              write strobe, one sample per high cycle
// - TONE       in   32             sample word (signed two's complement)
// - CLR_STATUS in   1              clears OVERFLOW and UNDERRUN
// - FIFO_FULL  out  1              level == DEPTH
// - FIFO_EMPTY out  1              level == 0
// - FIFO_LEVEL out  $clog2(DEPTH)+1  occupancy
// - OVERFLOW   out  1              sticky: write attempted while full
// - UNDERRUN   out  1              sticky: frame pop found FIFO empty
// - I2S_BCLK   out  1              bit clock
// - I2S_LRCLK  out  1              0 = left slot, 1 = right slot
// - I2S_DACDAT out  1              serial data, changes on BCLK falling edge
// BEHAVIOUR
// - Clock and reset: one clock, CLK. RESET is asynchronous and active-high.
// - Reset values: BCLK=0, LRCLK=0, DACDAT=0, FULL=0, EMPTY=1, LEVEL=0, OVERFLOW=0, UNDERRUN=0.
//   Rd/wr pointers, div_cnt, bit_cnt, shift register and held sample all 0.
//   Reset mid-frame aborts the frame and discards FIFO contents.
// - FIFO write: accepted iff LD_FIFO && !FIFO_FULL, using registered flags.
//   The write is visible in LEVEL/EMPTY on the next cycle.
//   A write while full is dropped and sets OVERFLOW. Contents are unchanged.
// - Simultaneous push and pop: LEVEL unchanged. If full, the push is still rejected.
//   If empty, the pop underruns; there is no fall-through.
// - Pointers wrap modulo DEPTH.
// - Divider: div_cnt counts 0..BCLK_DIV-1 while ENABLE. At terminal count, BCLK toggles.
//   A 1->0 toggle is the "fall event".
// - bit_cnt counts 0..2*FRAME_BITS-1 and advances on each fall event, wrapping to 0.
// - LRCLK goes to 1 at the fall event where bit_cnt becomes FRAME_BITS-1.
//   It goes to 0 where bit_cnt becomes 2*FRAME_BITS-1 (one-bit I2S lead).
// - Pop: at the fall event where bit_cnt becomes 2*FRAME_BITS-1, pop one entry into the held sample.
//   If the FIFO is empty, set UNDERRUN and apply the underrun policy (CONFIGURATION).
// - Shift: at bit_cnt becoming 0 (left) and FRAME_BITS (right), load the shift register with the held sample.
//   DACDAT = sample MSB at that same fall event. Each later fall event shifts left.
//   Slot bits DATA_W..FRAME_BITS-1 drive 0.
// - Output latency: LD_FIFO into an empty FIFO reaches DACDAT at the next frame pop + 1 BCLK.
// - ENABLE=0: at the next CLK edge, clear div_cnt and bit_cnt, force BCLK/LRCLK/DACDAT to 0, no pops.
//   On re-enable, the first fall event makes bit_cnt=1. The first pop comes at the first wrap to 2*FRAME_BITS-1.
// - CLR_STATUS has priority over a same-cycle set event, so both flags read 0 next cycle.
// CONFIGURATION
// - UNDERRUN_HOLD_EN defined: on underrun the held sample keeps its previous value (repeat last sample).
// - UNDERRUN_HOLD_EN undefined: on underrun the held sample is forced to 0 (mute).
// - UNDERRUN is flagged in both builds.
// TESTING
// - Reset, ENABLE=0 -> all outputs at reset values; LEVEL=0, EMPTY=1, no BCLK edges.
// - Write 16 samples, then a 17th with ENABLE=0 -> FULL=1, LEVEL=16, OVERFLOW=1;
//   the 17th is absent from later output; CLR_STATUS -> OVERFLOW=0.
// - ENABLE=1, TONE=32'hA5A5_A500 -> BCLK period 16 CLK.
//   LRCLK period 64 BCLK, high for bit_cnt 31..62.
//   L and R slots each shift 24'hA5A5A5 MSB-first, then 8 zeros; one pop per frame.
// - FIFO empty through a pop point, last sample 32'h1234_5600 -> UNDERRUN=1.
//   Next frame sends 24'h123456 with UNDERRUN_HOLD_EN, 24'h000000 without.
// - LD_FIFO on the same cycle as a pop with LEVEL=16 -> write rejected, OVERFLOW=1, LEVEL=15.
//   With LEVEL=0 -> UNDERRUN=1, LEVEL=1 next cycle.
// - Assert RESET mid-right-slot -> outputs return to reset values asynchronously;
//   after release with 1 sample written, the first frame sends that sample.

Source files
------------

// File: rtl/audio_fifo_i2s_if.sv
`default_nettype none
// ============================================================================
//  Module   : audio_fifo_i2s_if
//  Purpose  : Bundles the sample-write port, status flags and I2S pins of
//             audio_fifo_i2s. The design uses the slave view; the voice engine
//             and codec side use the master view.
//  Revision : 1.0 - initial release
// ============================================================================
interface audio_fifo_i2s_if #(
    parameter int DEPTH = 16
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             enable_i;
    logic             ld_fifo_i;
    logic [31:0]      tone_i;
    logic             clr_status_i;
    logic             fifo_full_o;
    logic             fifo_empty_o;
    logic [LVL_W-1:0] fifo_level_o;
    logic             overflow_o;
    logic             underrun_o;
    logic             i2s_bclk_o;
    logic             i2s_lrclk_o;
    logic             i2s_dacdat_o;

    modport slave (
        input  enable_i, ld_fifo_i, tone_i, clr_status_i,
        output fifo_full_o, fifo_empty_o, fifo_level_o, overflow_o, underrun_o,
        output i2s_bclk_o, i2s_lrclk_o, i2s_dacdat_o
    );

    modport master (
        output enable_i, ld_fifo_i, tone_i, clr_status_i,
        input  fifo_full_o, fifo_empty_o, fifo_level_o, overflow_o, underrun_o,
        input  i2s_bclk_o, i2s_lrclk_o, i2s_dacdat_o
    );
endinterface
`default_nettype wire

// File: rtl/audio_fifo_i2s.sv
`default_nettype none
// ============================================================================
//  Module   : audio_fifo_i2s
//  Purpose  : Sample FIFO plus I2S transmitter behind the synth voice engine.
//             Stores the top DATA_W bits of each TONE word, pops one sample per
//             audio frame and sends it MSB-first on both L and R slots.
//  Options  : UNDERRUN_HOLD_EN - repeat the last sample on underrun
//             (undefined: mute the frame instead). UNDERRUN flags in both.
//  Revision : 1.0 - initial release
// ============================================================================
module audio_fifo_i2s #(
    parameter int DEPTH      = 16,
    parameter int DATA_W     = 24,
    parameter int BCLK_DIV   = 8,
    parameter int FRAME_BITS = 32
) (
    input  wire logic       clk_i,
    input  wire logic       rst_i,
    audio_fifo_i2s_if.slave bus
);
    localparam int AW   = $clog2(DEPTH);
    localparam int LW   = AW + 1;
    localparam int DIVW = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
    localparam int BW   = $clog2(2 * FRAME_BITS);

    localparam logic [DIVW-1:0] DIV_LAST = DIVW'(BCLK_DIV - 1);
    localparam logic [BW-1:0]   BIT_LAST = BW'(2 * FRAME_BITS - 1);
    localparam logic [BW-1:0]   BIT_LR   = BW'(FRAME_BITS - 1);
    localparam logic [BW-1:0]   BIT_R    = BW'(FRAME_BITS);
    localparam logic [LW-1:0]   LVL_FULL = LW'(DEPTH);

`ifdef UNDERRUN_HOLD_EN
    localparam bit HOLD_ON_UNDERRUN = 1'b1;
`else
    localparam bit HOLD_ON_UNDERRUN = 1'b0;
`endif

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              full_q, full_d;
    logic              empty_q, empty_d;
    logic              ovf_q, ovf_d;
    logic              udr_q, udr_d;
    logic [DATA_W-1:0] held_q, held_d;

    // Serialiser state
    logic [DIVW-1:0]   div_q, div_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic              bclk_q, bclk_d;
    logic              lrclk_q, lrclk_d;
    logic              dac_q, dac_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;

    logic          w_tick;
    logic          w_fall;
    logic [BW-1:0] w_bit_nxt;
    logic          w_pop_slot;
    logic          w_push;
    logic          w_pop;
    logic          w_ovf_ev;
    logic          w_udr_ev;

    // Frame timing strobes; all FIFO decisions use the registered flags
    assign w_tick     = bus.enable_i && (div_q == DIV_LAST);
    assign w_fall     = w_tick && bclk_q;
    assign w_bit_nxt  = (bit_q == BIT_LAST) ? '0 : bit_q + BW'(1);
    assign w_pop_slot = w_fall && (w_bit_nxt == BIT_LAST);
    assign w_push     = bus.ld_fifo_i && !full_q;
    assign w_pop      = w_pop_slot && !empty_q;
    assign w_ovf_ev   = bus.ld_fifo_i && full_q;
    assign w_udr_ev   = w_pop_slot && empty_q;

    // FIFO pointer/level/flag next state and held-sample update at the frame pop
    always_comb begin
        wr_ptr_d = w_push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = w_pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        level_d  = level_q;
        if (w_push && !w_pop) begin
            level_d = level_q + LW'(1);
        end else if (!w_push && w_pop) begin
            level_d = level_q - LW'(1);
        end
        full_d  = (level_d == LVL_FULL);
        empty_d = (level_d == '0);
        ovf_d   = bus.clr_status_i ? 1'b0 : (ovf_q | w_ovf_ev);
        udr_d   = bus.clr_status_i ? 1'b0 : (udr_q | w_udr_ev);
        held_d  = held_q;
        if (w_pop) begin
            held_d = mem_q[rd_ptr_q];
        end else if (w_udr_ev) begin
            held_d = HOLD_ON_UNDERRUN ? held_q : '0;
        end
    end

    // BCLK divider, slot counter, LRCLK and data shifter; idle forces everything low
    always_comb begin
        div_d   = div_q;
        bit_d   = bit_q;
        bclk_d  = bclk_q;
        lrclk_d = lrclk_q;
        dac_d   = dac_q;
        shreg_d = shreg_q;
        if (!bus.enable_i) begin
            div_d   = '0;
            bit_d   = '0;
            bclk_d  = 1'b0;
            lrclk_d = 1'b0;
            dac_d   = 1'b0;
            shreg_d = '0;
        end else begin
            div_d = w_tick ? '0 : div_q + DIVW'(1);
            if (w_tick) begin
                bclk_d = ~bclk_q;
            end
            if (w_fall) begin
                bit_d = w_bit_nxt;
                // LRCLK leads the slot by one bit, as I2S requires
                if (w_bit_nxt == BIT_LR) begin
                    lrclk_d = 1'b1;
                end else if (w_bit_nxt == BIT_LAST) begin
                    lrclk_d = 1'b0;
                end
                // Zero fill shifts in, so bits past DATA_W in a slot are 0
                if ((w_bit_nxt == '0) || (w_bit_nxt == BIT_R)) begin
                    dac_d   = held_q[DATA_W-1];
                    shreg_d = {held_q[DATA_W-2:0], 1'b0};
                end else begin
                    dac_d   = shreg_q[DATA_W-1];
                    shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
                end
            end
        end
    end

    // Sample storage; no reset needed since the pointers define validity
    always_ff @(posedge clk_i) begin
        if (w_push) begin
            mem_q[wr_ptr_q] <= bus.tone_i[31 -: DATA_W];
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ovf_q    <= 1'b0;
            udr_q    <= 1'b0;
            held_q   <= '0;
            div_q    <= '0;
            bit_q    <= '0;
            bclk_q   <= 1'b0;
            lrclk_q  <= 1'b0;
            dac_q    <= 1'b0;
            shreg_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ovf_q    <= ovf_d;
            udr_q    <= udr_d;
            held_q   <= held_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            bclk_q   <= bclk_d;
            lrclk_q  <= lrclk_d;
            dac_q    <= dac_d;
            shreg_q  <= shreg_d;
        end
    end

    // Low TONE bits below the transmitted width are intentionally dropped
    generate
        if (DATA_W < 32) begin : g_unused_tone
            logic w_unused_tone;
            assign w_unused_tone = ^bus.tone_i[31-DATA_W:0];
        end
    endgenerate

    assign bus.fifo_full_o  = full_q;
    assign bus.fifo_empty_o = empty_q;
    assign bus.fifo_level_o = level_q;
    assign bus.overflow_o   = ovf_q;
    assign bus.underrun_o   = udr_q;
    assign bus.i2s_bclk_o   = bclk_q;
    assign bus.i2s_lrclk_o  = lrclk_q;
    assign bus.i2s_dacdat_o = dac_q;
endmodule
`default_nettype wire

// File: tb/tb_audio_fifo_i2s.sv
`default_nettype none
// ============================================================================
//  Module   : tb_audio_fifo_i2s
//  Purpose  : Self-checking bench for audio_fifo_i2s. A behavioural model
//             derives BCLK/LRCLK/data from the count of enabled clock edges
//             and keeps the FIFO as a queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_audio_fifo_i2s;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    audio_fifo_i2s_if #(.DEPTH(16)) bus ();

    audio_fifo_i2s #(
        .DEPTH(16), .DATA_W(24), .BCLK_DIV(8), .FRAME_BITS(32)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Fall event k happens on the (16*k)-th enabled edge; slot bit = k mod 64.
    logic [23:0] m_q[$];
    logic [23:0] m_held = '0;
    logic [23:0] m_slot = '0;
    bit          m_bclk = 0, m_lrclk = 0, m_dac = 0, m_ovf = 0, m_udr = 0;
    int          m_en = 0, m_bit = 0, m_pre = 0;
    bit          m_pop = 0, m_ovf_ev = 0, m_udr_ev = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_q.delete();
            m_held = '0; m_slot = '0;
            m_bclk = 0; m_lrclk = 0; m_dac = 0; m_ovf = 0; m_udr = 0;
            m_en = 0; m_bit = 0;
        end else begin
            m_pre    = m_q.size();
            m_pop    = 0;
            m_ovf_ev = bus.ld_fifo_i && (m_pre == 16);
            m_udr_ev = 0;
            if (!bus.enable_i) begin
                m_en = 0; m_bit = 0; m_bclk = 0; m_lrclk = 0; m_dac = 0; m_slot = '0;
            end else begin
                m_en++;
                if (m_en % 8 == 0) m_bclk = ((m_en / 8) % 2) == 1;
                if (m_en % 16 == 0) begin
                    m_bit   = (m_en / 16) % 64;
                    m_lrclk = (m_bit >= 31) && (m_bit < 63);
                    if (m_bit == 0 || m_bit == 32) m_slot = m_held;
                    m_dac   = ((m_bit % 32) < 24) ? m_slot[23 - (m_bit % 32)] : 1'b0;
                    m_pop   = (m_bit == 63);
                end
            end
            if (m_pop) begin
                if (m_pre == 0) begin
                    m_udr_ev = 1;
`ifndef UNDERRUN_HOLD_EN
                    m_held = '0;
`endif
                end else begin
                    m_held = m_q.pop_front();
                end
            end
            if (bus.ld_fifo_i && m_pre < 16) m_q.push_back(bus.tone_i[31:8]);
            if (bus.clr_status_i) begin
                m_ovf = 0; m_udr = 0;
            end else begin
                m_ovf = m_ovf | m_ovf_ev;
                m_udr = m_udr | m_udr_ev;
            end
        end
    end

    // ---------------- utilities ----------------
    task automatic apply_reset();
        rst = 1'b1;
        bus.enable_i = 1'b0; bus.ld_fifo_i = 1'b0; bus.clr_status_i = 1'b0; bus.tone_i = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_fall();
        logic prev;
        int   n;
        bit   done;
        prev = bus.i2s_bclk_o; n = 0; done = 0;
        while (!done) begin
            @(negedge clk);
            n++;
            if (prev === 1'b1 && bus.i2s_bclk_o === 1'b0) begin
                done = 1;
            end else if (n > 40) begin
                checks++; errors++;
                $display("FAIL wait_fall no BCLK fall within 40 cycles, bclk=%b", bus.i2s_bclk_o);
                done = 1;
            end
            prev = bus.i2s_bclk_o;
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        int   edges;
        logic prev;
        apply_reset();
        edges = 0; prev = bus.i2s_bclk_o;
        repeat (40) begin
            @(negedge clk);
            if (bus.i2s_bclk_o !== prev) edges++;
            prev = bus.i2s_bclk_o;
        end
        checks++; if (edges != 0) begin errors++; $display("FAIL reset_bclk_edges got %0d want 0", edges); end
        checks++; if (bus.i2s_bclk_o !== 1'b0) begin errors++; $display("FAIL reset_bclk got %b want 0", bus.i2s_bclk_o); end
        checks++; if (bus.i2s_lrclk_o !== 1'b0) begin errors++; $display("FAIL reset_lrclk got %b want 0", bus.i2s_lrclk_o); end
        checks++; if (bus.i2s_dacdat_o !== 1'b0) begin errors++; $display("FAIL reset_dacdat got %b want 0", bus.i2s_dacdat_o); end
        checks++; if (bus.fifo_full_o !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.fifo_full_o); end
        checks++; if (bus.fifo_empty_o !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", bus.fifo_empty_o); end
        checks++; if (bus.fifo_level_o !== 5'd0) begin errors++; $display("FAIL reset_level got %0d want 0", bus.fifo_level_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL reset_overflow got %b want 0", bus.overflow_o); end
        checks++; if (bus.underrun_o !== 1'b0) begin errors++; $display("FAIL reset_underrun got %b want 0", bus.underrun_o); end
    endtask

    task automatic test_fill_overflow();
        for (int i = 0; i < 16; i++) begin
            bus.ld_fifo_i = 1'b1; bus.tone_i = $urandom;
            @(negedge clk);
            if (i == 0) begin
                checks++; if (bus.fifo_level_o !== 5'd1 || bus.fifo_empty_o !== 1'b0) begin
                    errors++; $display("FAIL first_write level=%0d empty=%b want 1/0", bus.fifo_level_o, bus.fifo_empty_o); end
            end
        end
        bus.tone_i = $urandom;   // 17th write, must be dropped
        @(negedge clk);
        bus.ld_fifo_i = 1'b0;
        checks++; if (bus.fifo_full_o !== 1'b1) begin errors++; $display("FAIL ovf_full got %b want 1", bus.fifo_full_o); end
        checks++; if (bus.fifo_level_o !== 5'd16) begin errors++; $display("FAIL ovf_level got %0d want 16", bus.fifo_level_o); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", bus.overflow_o); end
        bus.clr_status_i = 1'b1;
        @(negedge clk);
        bus.clr_status_i = 1'b0;
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", bus.overflow_o); end
        checks++; if (bus.fifo_level_o !== 5'(m_q.size())) begin
            errors++; $display("FAIL ovf_model_level got %0d want %0d", bus.fifo_level_o, m_q.size()); end
    endtask

    task automatic test_stream();
        logic [11:0] got, exp;
        bus.enable_i = 1'b1;
        for (int c = 0; c < 17 * 1024; c++) begin
            bus.ld_fifo_i    = ($urandom_range(0, 899) == 0);
            bus.tone_i       = $urandom;
            bus.clr_status_i = ($urandom_range(0, 2999) == 0);
            @(negedge clk);
            exp = {m_bclk, m_lrclk, m_dac, (m_q.size() == 16), (m_q.size() == 0), m_ovf, m_udr, 5'(m_q.size())};
            got = {bus.i2s_bclk_o, bus.i2s_lrclk_o, bus.i2s_dacdat_o, bus.fifo_full_o, bus.fifo_empty_o,
                   bus.overflow_o, bus.underrun_o, bus.fifo_level_o};
            checks++;
            if (got !== exp) begin
                errors++;
                $display("FAIL stream cyc %0d {bclk,lr,dat,full,empty,ovf,udr,lvl} got %b want %b", c, got, exp);
            end
        end
        bus.ld_fifo_i = 1'b0; bus.clr_status_i = 1'b0;
    endtask

    task automatic test_pattern();
        int          cyc, r1, r2, k;
        logic        prev, lr_exp;
        logic [63:0] word;
        apply_reset();
        bus.ld_fifo_i = 1'b1; bus.tone_i = 32'hA5A5_A500;
        repeat (2) @(negedge clk);
        bus.ld_fifo_i = 1'b0;
        bus.enable_i  = 1'b1;
        cyc = 0; r1 = -1; r2 = -1; prev = bus.i2s_bclk_o;
        repeat (40) begin
            @(negedge clk);
            cyc++;
            if (!prev && bus.i2s_bclk_o) begin
                if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
            end
            prev = bus.i2s_bclk_o;
        end
        checks++; if (r1 != 8) begin errors++; $display("FAIL bclk_first_rise got %0d want 8", r1); end
        checks++; if (r2 - r1 != 16) begin errors++; $display("FAIL bclk_period got %0d want 16", r2 - r1); end
        k = 0;
        while (bus.fifo_level_o !== 5'd1 && k < 80) begin wait_fall(); k++; end
        checks++; if (bus.fifo_level_o !== 5'd1) begin errors++; $display("FAIL pattern_pop1 level got %0d want 1", bus.fifo_level_o); end
        word = '0;
        for (int j = 0; j < 64; j++) begin
            wait_fall();
            word[63 - j] = bus.i2s_dacdat_o;
            lr_exp = (j >= 31) && (j < 63);
            checks++; if (bus.i2s_lrclk_o !== lr_exp) begin
                errors++; $display("FAIL pattern_lrclk bit %0d got %b want %b", j, bus.i2s_lrclk_o, lr_exp); end
        end
        checks++; if (word !== 64'hA5A5A500_A5A5A500) begin errors++; $display("FAIL pattern_frame got %h want a5a5a500a5a5a500", word); end
        checks++; if (bus.fifo_level_o !== 5'd0) begin errors++; $display("FAIL pattern_pop2 level got %0d want 0", bus.fifo_level_o); end
    endtask

    task automatic test_underrun();
        logic [31:0] w;
        logic [23:0] want;
        bus.ld_fifo_i = 1'b1; bus.tone_i = 32'h1234_5600;
        @(negedge clk);
        bus.ld_fifo_i = 1'b0;
        for (int j = 0; j < 64; j++) wait_fall();
        w = '0;
        for (int j = 0; j < 64; j++) begin
            wait_fall();
            if (j < 32) w[31 - j] = bus.i2s_dacdat_o;
            if (j == 62) begin
                checks++; if (bus.underrun_o !== 1'b0) begin errors++; $display("FAIL udr_early got %b want 0", bus.underrun_o); end
            end
        end
        checks++; if (w !== 32'h1234_5600) begin errors++; $display("FAIL udr_sample got %h want 12345600", w); end
        checks++; if (bus.underrun_o !== 1'b1) begin errors++; $display("FAIL udr_flag got %b want 1", bus.underrun_o); end
        checks++; if (bus.fifo_level_o !== 5'd0) begin errors++; $display("FAIL udr_level got %0d want 0", bus.fifo_level_o); end
`ifdef UNDERRUN_HOLD_EN
        want = 24'h123456;
`else
        want = 24'h000000;
`endif
        w = '0;
        for (int j = 0; j < 32; j++) begin wait_fall(); w[31 - j] = bus.i2s_dacdat_o; end
        checks++; if (w !== {want, 8'h00}) begin errors++; $display("FAIL udr_policy got %h want %h", w, {want, 8'h00}); end
    endtask

    task automatic test_collision();
        int k;
        // Full FIFO on the pop cycle: push rejected, pop proceeds
        apply_reset();
        bus.enable_i = 1'b1;
        for (int i = 0; i < 16; i++) begin
            bus.ld_fifo_i = 1'b1; bus.tone_i = $urandom;
            @(negedge clk);
        end
        bus.ld_fifo_i = 1'b0;
        k = 0;
        while ((m_en + 1) % 1024 != 1008 && k < 1100) begin @(negedge clk); k++; end
        checks++; if (k >= 1100) begin errors++; $display("FAIL coll_full_wait timeout got %0d want <1100", k); end
        bus.ld_fifo_i = 1'b1; bus.tone_i = $urandom;
        @(negedge clk);
        bus.ld_fifo_i = 1'b0;
        checks++; if (bus.fifo_level_o !== 5'd15) begin errors++; $display("FAIL coll_full_level got %0d want 15", bus.fifo_level_o); end
        checks++; if (bus.overflow_o !== 1'b1) begin errors++; $display("FAIL coll_full_ovf got %b want 1", bus.overflow_o); end
        checks++; if (bus.underrun_o !== 1'b0) begin errors++; $display("FAIL coll_full_udr got %b want 0", bus.underrun_o); end
        // Empty FIFO on the pop cycle: underrun, push lands
        apply_reset();
        bus.enable_i = 1'b1;
        k = 0;
        while ((m_en + 1) % 1024 != 1008 && k < 1100) begin @(negedge clk); k++; end
        checks++; if (k >= 1100) begin errors++; $display("FAIL coll_empty_wait timeout got %0d want <1100", k); end
        bus.ld_fifo_i = 1'b1; bus.tone_i = $urandom;
        @(negedge clk);
        bus.ld_fifo_i = 1'b0;
        checks++; if (bus.underrun_o !== 1'b1) begin errors++; $display("FAIL coll_empty_udr got %b want 1", bus.underrun_o); end
        checks++; if (bus.fifo_level_o !== 5'd1) begin errors++; $display("FAIL coll_empty_level got %0d want 1", bus.fifo_level_o); end
        checks++; if (bus.overflow_o !== 1'b0) begin errors++; $display("FAIL coll_empty_ovf got %b want 0", bus.overflow_o); end
    endtask

    task automatic test_reset_mid();
        int          k;
        logic [10:0] got;
        logic [31:0] s, w;
        k = 0;
        while (!(bus.i2s_lrclk_o === 1'b1 && m_bit >= 40 && m_bit <= 50) && k < 2100) begin @(negedge clk); k++; end
        checks++; if (k >= 2100) begin errors++; $display("FAIL rmid_wait timeout got %0d want <2100", k); end
        #2 rst = 1'b1;
        #1;
        got = {bus.i2s_bclk_o, bus.i2s_lrclk_o, bus.i2s_dacdat_o, bus.fifo_full_o, bus.fifo_empty_o,
               bus.overflow_o, bus.underrun_o, bus.fifo_level_o[3:0]};
        checks++; if (got !== 11'b000_0100_0000) begin
            errors++; $display("FAIL rmid_async {bclk,lr,dat,full,empty,ovf,udr,lvl} got %b want 00001000000", got); end
        checks++; if (bus.fifo_level_o !== 5'd0) begin errors++; $display("FAIL rmid_level got %0d want 0", bus.fifo_level_o); end
        @(negedge clk);
        rst = 1'b0; bus.enable_i = 1'b0;
        s = $urandom;
        bus.ld_fifo_i = 1'b1; bus.tone_i = s;
        @(negedge clk);
        bus.ld_fifo_i = 1'b0; bus.enable_i = 1'b1;
        k = 0;
        while (bus.fifo_level_o !== 5'd0 && k < 80) begin wait_fall(); k++; end
        checks++; if (bus.fifo_level_o !== 5'd0) begin errors++; $display("FAIL rmid_pop level got %0d want 0", bus.fifo_level_o); end
        w = '0;
        for (int j = 0; j < 32; j++) begin wait_fall(); w[31 - j] = bus.i2s_dacdat_o; end
        checks++; if (w !== {s[31:8], 8'h00}) begin errors++; $display("FAIL rmid_first_frame got %h want %h", w, {s[31:8], 8'h00}); end
    endtask

    initial begin
        bus.enable_i = 1'b0; bus.ld_fifo_i = 1'b0; bus.clr_status_i = 1'b0; bus.tone_i = '0;
        test_reset();
        test_fill_overflow();
        test_stream();
        test_pattern();
        test_underrun();
        test_collision();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
